// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the BRAM FIFO capture path: FSM encoding and
// capture-size constants used by the controller.
package bram_fifo_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
    localparam logic [1:0] ST_CAPTURE   = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam int unsigned EXP_OFFSET = 8;
    localparam int unsigned EXP_CLAMP  = 16;
    localparam int unsigned GRP_CNT_W  = 25;

    // Requests beyond the largest supported capture saturate rather than wrap.
    function automatic logic [4:0] clamp_exp(input logic [4:0] exp);
        return (exp > 5'(EXP_CLAMP)) ? 5'(EXP_CLAMP) : exp;
    endfunction

endpackage

// File: rtl/bram_fifo_trig_sync.sv
// Two-flop synchronizer for the asynchronous external trigger followed by a
// rising-edge detector in the write clock domain.
module bram_fifo_trig_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/bram_fifo_capture_ctrl.sv
// Capture controller: arms on start, waits for trigger or timeout, then
// issues one FIFO write enable per ADC word group until the target is hit.
module bram_fifo_capture_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int unsigned WORD_NUM_LOG2 = 3,
    parameter int unsigned TMO_W         = 24
) (
    input  logic                 i_bram_fifo_wr_clk,
    input  logic                 i_bram_fifo_reset_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [4:0]           i_capture_req_exp,
    input  logic                 i_ext_trig,
    input  logic                 i_ext_trig_en,
    input  logic [TMO_W-1:0]     i_trig_timeout,
    input  logic                 i_adc_valid,
    input  logic                 i_fifo_almost_full,
    output logic                 o_wr_clk_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic                 o_trunc,
    output logic [GRP_CNT_W-1:0] o_grp_cnt
);

    logic [1:0]           state_q,   state_d;
    logic [4:0]           exp_q,     exp_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [GRP_CNT_W-1:0] grp_cnt_q, grp_cnt_d;
    logic                 wr_en_q,   wr_en_d;
    logic                 done_q,    done_d;
    logic                 timeout_q, timeout_d;
    logic                 trunc_q,   trunc_d;

    logic                 trig_rise;
    logic [TMO_W-1:0]     tmo_next;
    logic [GRP_CNT_W-1:0] target;
    logic                 complete;

    bram_fifo_trig_sync u_trig_sync (
        .clk_i  (i_bram_fifo_wr_clk),
        .rst_ni (i_bram_fifo_reset_n),
        .trig_i (i_ext_trig),
        .rise_o (trig_rise)
    );

    assign target   = GRP_CNT_W'(1) << (32'(exp_q) + EXP_OFFSET - WORD_NUM_LOG2);
    assign complete = (grp_cnt_q >= target);
    assign tmo_next = tmo_cnt_q + TMO_W'(1);

    // The group count advances together with the registered enable, so the
    // target compare already accounts for the write in flight.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        tmo_cnt_d = tmo_cnt_q;
        grp_cnt_d = grp_cnt_q;
        wr_en_d   = 1'b0;
        done_d    = done_q;
        timeout_d = timeout_q;
        trunc_d   = trunc_q;

        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_d   = ST_WAIT_TRIG;
                        exp_d     = clamp_exp(i_capture_req_exp);
                        tmo_cnt_d = '0;
                        grp_cnt_d = '0;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        trunc_d   = 1'b0;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (!i_ext_trig_en || trig_rise) begin
                        state_d = ST_CAPTURE;
                    end else if ((i_trig_timeout != '0) && (tmo_next == i_trig_timeout)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_next;
                    end
                end
                ST_CAPTURE: begin
                    if (complete) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (i_fifo_almost_full) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        trunc_d = 1'b1;
                    end else if (i_adc_valid) begin
                        wr_en_d   = 1'b1;
                        grp_cnt_d = grp_cnt_q + GRP_CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_bram_fifo_wr_clk or negedge i_bram_fifo_reset_n) begin
        if (!i_bram_fifo_reset_n) begin
            state_q   <= ST_IDLE;
            exp_q     <= '0;
            tmo_cnt_q <= '0;
            grp_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            tmo_cnt_q <= tmo_cnt_d;
            grp_cnt_q <= grp_cnt_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            trunc_q   <= trunc_d;
        end
    end

    assign o_wr_clk_en = wr_en_q;
    assign o_busy      = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;
    assign o_trunc     = trunc_q;
    assign o_grp_cnt   = grp_cnt_q;

endmodule

// File: tb/tb_bram_fifo_capture_ctrl.sv
// Directed bench for bram_fifo_capture_ctrl: each step drives inputs on the
// falling edge and compares outputs against hand-derived values.
module tb_bram_fifo_capture_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_abort;
    logic [4:0]  i_capture_req_exp;
    logic        i_ext_trig;
    logic        i_ext_trig_en;
    logic [23:0] i_trig_timeout;
    logic        i_adc_valid;
    logic        i_fifo_almost_full;
    logic        o_wr_clk_en;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic        o_trunc;
    logic [24:0] o_grp_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_total = 0;
    int base;

    bram_fifo_capture_ctrl #(
        .WORD_NUM_LOG2 (3),
        .TMO_W         (24)
    ) dut (
        .i_bram_fifo_wr_clk  (clk),
        .i_bram_fifo_reset_n (rst_n),
        .i_start             (i_start),
        .i_abort             (i_abort),
        .i_capture_req_exp   (i_capture_req_exp),
        .i_ext_trig          (i_ext_trig),
        .i_ext_trig_en       (i_ext_trig_en),
        .i_trig_timeout      (i_trig_timeout),
        .i_adc_valid         (i_adc_valid),
        .i_fifo_almost_full  (i_fifo_almost_full),
        .o_wr_clk_en         (o_wr_clk_en),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_timeout           (o_timeout),
        .o_trunc             (o_trunc),
        .o_grp_cnt           (o_grp_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (o_wr_clk_en === 1'b1) pulse_total <= pulse_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic start_cap(input logic [4:0] exp);
        i_capture_req_exp = exp;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic abort_cap();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_capture_req_exp = '0;
        i_ext_trig = 1'b0;
        i_ext_trig_en = 1'b0;
        i_trig_timeout = '0;
        i_adc_valid = 1'b0;
        i_fifo_almost_full = 1'b0;

        // reset state
        repeat (2) tick();
        chk("rst_wr_en",   32'(o_wr_clk_en), 0);
        chk("rst_busy",    32'(o_busy),      0);
        chk("rst_done",    32'(o_done),      0);
        chk("rst_timeout", 32'(o_timeout),   0);
        chk("rst_trunc",   32'(o_trunc),     0);
        chk("rst_grp",     32'(o_grp_cnt),   0);
        rst_n = 1'b1;
        tick();

        // trigger disabled, exp=0, continuous valid: 32 groups
        i_adc_valid = 1'b1;
        base = pulse_total;
        start_cap(5'd0);
        chk("t1_busy", 32'(o_busy), 1);
        repeat (33) tick();
        chk("t1_grp_last",   32'(o_grp_cnt),   32);
        chk("t1_wr_en_last", 32'(o_wr_clk_en), 1);
        chk("t1_done_early", 32'(o_done),      0);
        tick();
        chk("t1_done",    32'(o_done),             1);
        chk("t1_wr_off",  32'(o_wr_clk_en),        0);
        chk("t1_idle",    32'(o_busy),             0);
        chk("t1_pulses",  32'(pulse_total - base), 32);
        chk("t1_trunc",   32'(o_trunc),            0);
        chk("t1_timeout", 32'(o_timeout),          0);

        // trigger wait timeout after 100 cycles
        i_ext_trig_en = 1'b1;
        i_trig_timeout = 24'd100;
        base = pulse_total;
        start_cap(5'd0);
        chk("t2_done_clr", 32'(o_done), 0);
        repeat (99) tick();
        chk("t2_tmo_99",  32'(o_timeout), 0);
        chk("t2_busy_99", 32'(o_busy),    1);
        tick();
        chk("t2_tmo",    32'(o_timeout),          1);
        chk("t2_done",   32'(o_done),             0);
        chk("t2_busy",   32'(o_busy),             0);
        chk("t2_pulses", 32'(pulse_total - base), 0);
        chk("t2_grp",    32'(o_grp_cnt),          0);

        // external trigger, start ignored mid-capture, abort at group 10
        i_trig_timeout = '0;
        base = pulse_total;
        start_cap(5'd0);
        chk("t3_tmo_clr", 32'(o_timeout), 0);
        repeat (3) tick();
        chk("t3_wait_busy", 32'(o_busy),    1);
        chk("t3_wait_grp",  32'(o_grp_cnt), 0);
        i_ext_trig = 1'b1;
        repeat (3) tick();
        chk("t3_cap_wr0", 32'(o_wr_clk_en), 0);
        tick();
        chk("t3_cap_wr1", 32'(o_wr_clk_en), 1);
        chk("t3_grp1",    32'(o_grp_cnt),   1);
        repeat (4) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t3_start_ign", 32'(o_grp_cnt), 6);
        repeat (4) tick();
        chk("t3_grp10", 32'(o_grp_cnt), 10);
        abort_cap();
        chk("t3_abort_busy", 32'(o_busy),      0);
        chk("t3_abort_wr",   32'(o_wr_clk_en), 0);
        repeat (20) tick();
        chk("t3_pulses", 32'(pulse_total - base), 10);
        chk("t3_done",   32'(o_done),             0);
        chk("t3_grp",    32'(o_grp_cnt),          10);
        i_ext_trig = 1'b0;
        i_ext_trig_en = 1'b0;

        // abort wins over a coincident start
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("abort_prio_busy", 32'(o_busy), 0);

        // exp=5, almost-full after 500 groups
        base = pulse_total;
        start_cap(5'd5);
        for (int n = 0; n < 3000 && o_grp_cnt != 25'd500; n++) tick();
        chk("t4_grp_reach", 32'(o_grp_cnt), 500);
        i_fifo_almost_full = 1'b1;
        tick();
        i_fifo_almost_full = 1'b0;
        chk("t4_trunc",  32'(o_trunc),            1);
        chk("t4_done",   32'(o_done),             1);
        chk("t4_busy",   32'(o_busy),             0);
        chk("t4_grp",    32'(o_grp_cnt),          500);
        chk("t4_pulses", 32'(pulse_total - base), 500);
        chk("t4_wr_off", 32'(o_wr_clk_en),        0);

        // count-complete coinciding with almost-full leaves trunc clear
        start_cap(5'd0);
        chk("t5_trunc_clr", 32'(o_trunc), 0);
        repeat (33) tick();
        chk("t5_grp", 32'(o_grp_cnt), 32);
        i_fifo_almost_full = 1'b1;
        tick();
        i_fifo_almost_full = 1'b0;
        chk("t5_done",  32'(o_done),  1);
        chk("t5_trunc", 32'(o_trunc), 0);

        // valid toggling: 32 writes spread over 64 cycles
        base = pulse_total;
        i_adc_valid = 1'b1;
        start_cap(5'd0);
        for (int k = 1; k <= 64; k++) begin
            i_adc_valid = (k % 2 == 0);
            tick();
        end
        chk("t6_grp",       32'(o_grp_cnt), 32);
        chk("t6_done_early", 32'(o_done),   0);
        i_adc_valid = 1'b0;
        tick();
        chk("t6_done",   32'(o_done),             1);
        chk("t6_pulses", 32'(pulse_total - base), 32);

        // exp=20 clamps to 16: capture keeps running well past 32 groups
        i_adc_valid = 1'b1;
        start_cap(5'd20);
        repeat (100) tick();
        chk("t6b_grp",  32'(o_grp_cnt), 99);
        chk("t6b_busy", 32'(o_busy),    1);
        chk("t6b_done", 32'(o_done),    0);
        abort_cap();

        // asynchronous reset in the middle of a capture
        start_cap(5'd0);
        repeat (10) tick();
        chk("t7_grp_pre", 32'(o_grp_cnt), 9);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_wr",    32'(o_wr_clk_en), 0);
        chk("t7_rst_busy",  32'(o_busy),      0);
        chk("t7_rst_grp",   32'(o_grp_cnt),   0);
        chk("t7_rst_done",  32'(o_done),      0);
        chk("t7_rst_tmo",   32'(o_timeout),   0);
        chk("t7_rst_trunc", 32'(o_trunc),     0);
        @(negedge clk);
        base = pulse_total;
        repeat (3) tick();
        chk("t7_rst_pulses", 32'(pulse_total - base), 0);
        rst_n = 1'b1;
        tick();
        base = pulse_total;
        start_cap(5'd0);
        repeat (33) tick();
        chk("t7_grp", 32'(o_grp_cnt), 32);
        tick();
        chk("t7_done",   32'(o_done),             1);
        chk("t7_pulses", 32'(pulse_total - base), 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
